// File: rtl/mcu_transpose_8x8_if.sv
// Row-in / column-out bus of the 8x8 ping-pong transpose buffer.
// The slave modport is the buffer's side; the master modport drives rows and accepts columns.
interface mcu_transpose_8x8_if #(
   parameter int WIDTH = 8
);
   logic [7:0][WIDTH-1:0] din;
   logic                  din_valid;
   logic [7:0][WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  overflow;

   modport master (
      output din, din_valid, dout_ready,
      input  dout, dout_valid, overflow
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output dout, dout_valid, overflow
   );
endinterface

// File: rtl/mcu_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the other
// bank drains column by column on a valid/ready port.
module mcu_transpose_8x8 #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   mcu_transpose_8x8_if.slave  bus
);

   localparam int N = 32'sd8;

   logic [WIDTH-1:0]      bank_r [2][8][8];
   logic [1:0]            full_r, full_s;
   logic                  wr_bank_r, wr_bank_s;
   logic                  rd_bank_r, rd_bank_s;
   logic [2:0]            wr_row_r, wr_row_s;
   logic [2:0]            rd_col_r, rd_col_s;
   logic                  overflow_r, overflow_s;
   logic                  dout_valid_r;
   logic                  rd_xfer_s, free_s, wr_ok_s;
   logic [7:0][WIDTH-1:0] dout_s;

   // Next-state for pointers, full flags and overflow; a bank freed this cycle may be rewritten at once.
   always_comb begin
      rd_xfer_s  = dout_valid_r & bus.dout_ready;
      free_s     = rd_xfer_s & (rd_col_r == 3'd7);
      wr_ok_s    = bus.din_valid &
                   (~full_r[wr_bank_r] | (free_s & (rd_bank_r == wr_bank_r)));
      full_s     = full_r;
      wr_bank_s  = wr_bank_r;
      wr_row_s   = wr_row_r;
      rd_bank_s  = rd_bank_r;
      rd_col_s   = rd_col_r;
      overflow_s = overflow_r | (bus.din_valid & ~wr_ok_s);
      if (wr_ok_s) begin
         if (wr_row_r == 3'd7) begin
            full_s[wr_bank_r] = 1'b1;
            wr_bank_s         = ~wr_bank_r;
            wr_row_s          = 3'd0;
         end else begin
            wr_row_s = wr_row_r + 3'd1;
         end
      end else begin
         wr_row_s = wr_row_r;
      end
      // The clear comes after the set so a free wins on the same bank.
      if (rd_xfer_s) begin
         if (free_s) begin
            full_s[rd_bank_r] = 1'b0;
            rd_bank_s         = ~rd_bank_r;
            rd_col_s          = 3'd0;
         end else begin
            rd_col_s = rd_col_r + 3'd1;
         end
      end else begin
         rd_col_s = rd_col_r;
      end
   end

   // Control state registers; dout_valid is registered from the next full/rd_bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r       <= 2'b00;
         wr_bank_r    <= 1'b0;
         wr_row_r     <= 3'd0;
         rd_bank_r    <= 1'b0;
         rd_col_r     <= 3'd0;
         overflow_r   <= 1'b0;
         dout_valid_r <= 1'b0;
      end else begin
         full_r       <= full_s;
         wr_bank_r    <= wr_bank_s;
         wr_row_r     <= wr_row_s;
         rd_bank_r    <= rd_bank_s;
         rd_col_r     <= rd_col_s;
         overflow_r   <= overflow_s;
         dout_valid_r <= full_s[rd_bank_s];
      end
   end

   // Pixel storage: an accepted row lands in the current write bank and row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < N; r++) begin
               for (int c = 0; c < N; c++) begin
                  bank_r[b][r][c] <= '0;
               end
            end
         end
      end else if (wr_ok_s) begin
         for (int j = 0; j < N; j++) begin
            bank_r[wr_bank_r][wr_row_r][j] <= bus.din[j];
         end
      end
   end

   // Column read mux: row i of the current column of the read bank.
   always_comb begin
      dout_s = '0;
      for (int i = 0; i < N; i++) begin
         dout_s[i] = bank_r[rd_bank_r][i][rd_col_r];
      end
   end

   assign bus.dout       = dout_s;
   assign bus.dout_valid = dout_valid_r;
   assign bus.overflow   = overflow_r;

endmodule
